bcd_updown_counter_n: RTL and testbench

//   Parametrised N-digit BCD up/down counter with parallel load, synchronous clear, hold,
//   and cascadable count-enable/terminal-count. Successor to the fixed 4-digit BCD counter.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit.sv | 51 +++++
 rtl/bcd_updown_counter_n.sv | 80 ++++++++
 tb/tb_bcd_updown_counter_n.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the N-digit BCD up/down counter.
//   mode_e  : 2-bit operating mode encodings (clear, up, down, hold)
//   BCD_MAX : largest legal BCD digit value
//   is_bcd  : returns 1 when a nibble is a legal BCD digit (0..9)
package bcd_pkg;

  typedef enum logic [1:0] {
    MODE_CLR  = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DN   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register of the N-digit counter.
// Ports:
//   clk     in  rising-edge clock
//   a_clr   in  asynchronous active-high reset (q <= RST_NIB, bad <= 0)
//   load_en in  parallel load strobe (priority over mode)
//   load_d  in  4-bit load value; an invalid nibble (>9) loads as 0
//   mode    in  2-bit mode (see bcd_pkg::mode_e)
//   en      in  digit step enable for up/down modes
//   q       out registered digit value
//   is9     out digit currently at 9
//   is0     out digit currently at 0
//   bad     out registered; 1 for one cycle after a load of an invalid nibble
module bcd_digit
  import bcd_pkg::*;
#(
  parameter logic [3:0] RST_NIB = 4'd0
) (
  input  logic       clk,
  input  logic       a_clr,
  input  logic       load_en,
  input  logic [3:0] load_d,
  input  logic [1:0] mode,
  input  logic       en,
  output logic [3:0] q,
  output logic       is9,
  output logic       is0,
  output logic       bad
);

  always_ff @(posedge clk or posedge a_clr) begin
    if (a_clr) begin
      q   <= RST_NIB;
      bad <= 1'b0;
    end else if (load_en) begin
      q   <= is_bcd(load_d) ? load_d : '0;
      bad <= ~is_bcd(load_d);
    end else begin
      bad <= 1'b0;
      case (mode)
        MODE_CLR: q <= RST_NIB;
        MODE_UP:  if (en) q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        MODE_DN:  if (en) q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
        default:  ;
      endcase
    end
  end

  assign is9 = (q == BCD_MAX);
  assign is0 = (q == 4'd0);

endmodule

// File: rtl/bcd_updown_counter_n.sv
// Parametrised N-digit BCD up/down counter with parallel load, synchronous
// clear, hold and cascadable count-enable / terminal-count.
// Optional feature macro: BCD_CNT_SATURATE_EN (saturate at all-9s / all-0s
// instead of wrapping; cout still flags the terminal value).
// Parameters:
//   DIGITS    number of BCD digits (1..8), W = 4*DIGITS
//   RST_VALUE reset / clear value, every nibble 0..9
// Ports:
//   clk      in  rising-edge clock
//   a_clr    in  asynchronous active-high reset
//   mode     in  00 clear, 01 up, 10 down, 11 hold
//   load_en  in  parallel load strobe (priority over mode)
//   load     in  W-bit load value, nibble k = digit k
//   cin      in  count enable / cascade carry-in
//   out      out registered BCD count
//   cout     out combinational terminal count for cascading
//   load_err out registered; 1 for one cycle after a load with any nibble > 9
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned             DIGITS    = 4,
  parameter logic [4*DIGITS-1:0]     RST_VALUE = '0
) (
  input  logic                clk,
  input  logic                a_clr,
  input  logic [1:0]          mode,
  input  logic                load_en,
  input  logic [4*DIGITS-1:0] load,
  input  logic                cin,
  output logic [4*DIGITS-1:0] out,
  output logic                cout,
  output logic                load_err
);

  logic [DIGITS-1:0] is9, is0, bad, en_raw, en;
  logic up, dn, all9, all0, at_limit;

  assign up       = (mode == MODE_UP);
  assign dn       = (mode == MODE_DN);
  assign all9     = &is9;
  assign all0     = &is0;
  assign at_limit = (up & all9) | (dn & all0);
  assign cout     = cin & ~load_en & at_limit;
  assign load_err = |bad;

  // Ripple enable: digit k steps only when every lower digit is at its
  // terminal value for the current direction.
  for (genvar k = 0; k < DIGITS; k++) begin : g_en
    if (k == 0) begin : g_lsd
      assign en_raw[k] = cin;
    end else begin : g_upper
      assign en_raw[k] = cin & ((up & (&is9[k-1:0])) | (dn & (&is0[k-1:0])));
    end
  end

`ifdef BCD_CNT_SATURATE_EN
  // At the terminal value every digit would wrap; freezing all enables holds it.
  assign en = en_raw & ~{DIGITS{at_limit}};
`else
  assign en = en_raw;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit #(
      .RST_NIB (RST_VALUE[4*k +: 4])
    ) u_digit (
      .clk     (clk),
      .a_clr   (a_clr),
      .load_en (load_en),
      .load_d  (load[4*k +: 4]),
      .mode    (mode),
      .en      (en[k]),
      .q       (out[4*k +: 4]),
      .is9     (is9[k]),
      .is0     (is0[k]),
      .bad     (bad[k])
    );
  end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
module tb_bcd_updown_counter_n;

  logic        clk = 1'b0;
  logic        a_clr;
  logic [1:0]  mode;
  logic        load_en;
  logic [15:0] load;
  logic        cin;
  logic [15:0] out;
  logic        cout;
  logic        load_err;

  // Cascade pair (two 2-digit stages)
  logic [1:0]  c_mode;
  logic        c_load_en;
  logic [15:0] c_load;
  logic        c_cin;
  logic [7:0]  lo_out, hi_out;
  logic        lo_cout, hi_cout, lo_err, hi_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: the count as a plain integer
  int mv;
  bit merr;

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.DIGITS(4), .RST_VALUE(16'h0000)) dut (
    .clk(clk), .a_clr(a_clr), .mode(mode), .load_en(load_en), .load(load),
    .cin(cin), .out(out), .cout(cout), .load_err(load_err)
  );

  bcd_updown_counter_n #(.DIGITS(2), .RST_VALUE(8'h00)) u_lo (
    .clk(clk), .a_clr(a_clr), .mode(c_mode), .load_en(c_load_en), .load(c_load[7:0]),
    .cin(c_cin), .out(lo_out), .cout(lo_cout), .load_err(lo_err)
  );

  bcd_updown_counter_n #(.DIGITS(2), .RST_VALUE(8'h00)) u_hi (
    .clk(clk), .a_clr(a_clr), .mode(c_mode), .load_en(c_load_en), .load(c_load[15:8]),
    .cin(lo_cout), .out(hi_out), .cout(hi_cout), .load_err(hi_err)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_cout(input logic ld, input logic [1:0] md, input logic ci);
    return ci && !ld && ((md == 2'b01 && mv == 9999) || (md == 2'b10 && mv == 0));
  endfunction

  task automatic model_edge(input logic ld, input logic [15:0] lv, input logic [1:0] md, input logic ci);
    int val, pw;
    logic [3:0] nib;
    if (ld) begin
      val = 0; pw = 1; merr = 0;
      for (int i = 0; i < 4; i++) begin
        nib = lv[4*i +: 4];
        if (nib > 9) merr = 1;
        else val += int'(nib) * pw;
        pw *= 10;
      end
      mv = val;
    end else begin
      merr = 0;
      case (md)
        2'b00: mv = 0;
        2'b01: if (ci) begin
`ifdef BCD_CNT_SATURATE_EN
                 if (mv != 9999) mv = mv + 1;
`else
                 mv = (mv + 1) % 10000;
`endif
               end
        2'b10: if (ci) begin
`ifdef BCD_CNT_SATURATE_EN
                 if (mv != 0) mv = mv - 1;
`else
                 mv = (mv + 9999) % 10000;
`endif
               end
        default: ;
      endcase
    end
  endtask

  // Apply one cycle of inputs (called just after a falling edge), check the
  // combinational cout before the rising edge and the registered outputs after it.
  task automatic step(input string tag, input logic ld, input logic [15:0] lv,
                      input logic [1:0] md, input logic ci);
    load_en = ld; load = lv; mode = md; cin = ci;
    #1;
    check({tag, ".cout"}, 32'(cout), 32'(model_cout(ld, md, ci)));
    @(posedge clk);
    model_edge(ld, lv, md, ci);
    #1;
    check({tag, ".out"}, 32'(out), 32'(to_bcd(mv)));
    check({tag, ".load_err"}, 32'(load_err), 32'(merr));
    @(negedge clk);
  endtask

  task automatic cstep(input string tag, input logic [1:0] md, input logic ci,
                       input logic [15:0] exp_out, input logic exp_lo_cout);
    c_mode = md; c_cin = ci; c_load_en = 1'b0;
    #1;
    check({tag, ".lo_cout"}, 32'(lo_cout), 32'(exp_lo_cout));
    @(posedge clk);
    #1;
    check({tag, ".out"}, 32'({hi_out, lo_out}), 32'(exp_out));
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] lv;
    logic [1:0]  md;
    logic        ld, ci;
    int          sel;

    a_clr = 1'b1; mode = 2'b11; load_en = 1'b0; load = '0; cin = 1'b0;
    c_mode = 2'b11; c_load_en = 1'b0; c_load = '0; c_cin = 1'b0;
    mv = 0; merr = 0;
    repeat (2) @(negedge clk);
    check("reset.out", 32'(out), 32'h0);
    check("reset.load_err", 32'(load_err), 32'h0);
    check("reset.cout", 32'(cout), 32'h0);
    a_clr = 1'b0;
    @(negedge clk);

    // Async clear mid-cycle while counting from 0123
    step("t1.load", 1'b1, 16'h0123, 2'b01, 1'b1);
    step("t1.up", 1'b0, 16'h0000, 2'b01, 1'b1);
    step("t1.up", 1'b0, 16'h0000, 2'b01, 1'b1);
    #2 a_clr = 1'b1;
    #1;
    check("t1.clr.out", 32'(out), 32'h0);
    check("t1.clr.load_err", 32'(load_err), 32'h0);
    mv = 0; merr = 0;
    @(negedge clk);
    a_clr = 1'b0;
    // Async clear also drops a pending load_err
    step("t1b.badload", 1'b1, 16'hA123, 2'b11, 1'b0);
    #2 a_clr = 1'b1;
    #1;
    check("t1b.clr.out", 32'(out), 32'h0);
    check("t1b.clr.load_err", 32'(load_err), 32'h0);
    mv = 0; merr = 0;
    @(negedge clk);
    a_clr = 1'b0;

    // Carry ripple through two digits
    step("t2.load", 1'b1, 16'h1299, 2'b11, 1'b0);
    step("t2.up1", 1'b0, 16'h0000, 2'b01, 1'b1);
    step("t2.up2", 1'b0, 16'h0000, 2'b01, 1'b1);
    check("t2.value", 32'(out), 32'h1301);

    // Up wrap (or saturate) from 9999
    step("t3.load", 1'b1, 16'h9999, 2'b01, 1'b1);
    step("t3.wrap", 1'b0, 16'h0000, 2'b01, 1'b1);
    step("t3.after", 1'b0, 16'h0000, 2'b01, 1'b1);

    // Down wrap from 0000, then hold
    step("t4.load", 1'b1, 16'h0000, 2'b10, 1'b1);
    step("t4.wrap", 1'b0, 16'h0000, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) step("t4.hold", 1'b0, 16'h0000, 2'b11, 1'b1);

    // Invalid-nibble load, one-cycle load_err, load beats clear
    step("t5.badload", 1'b1, 16'hA3F5, 2'b11, 1'b0);
    check("t5.value", 32'(out), 32'h0305);
    step("t5.errgone", 1'b0, 16'h0000, 2'b11, 1'b0);
    step("t5.loadwins", 1'b1, 16'h0042, 2'b00, 1'b1);
    step("t5.syncclr", 1'b0, 16'h0000, 2'b00, 1'b1);
    step("t5.cin0", 1'b0, 16'h0000, 2'b01, 1'b0);

    // Cascade of two 2-digit stages
    c_load = 16'h0098; c_load_en = 1'b1; c_mode = 2'b11;
    @(posedge clk); #1;
    check("t6.load", 32'({hi_out, lo_out}), 32'h0098);
    @(negedge clk);
    cstep("t6.up1", 2'b01, 1'b1, 16'h0099, 1'b0);
    cstep("t6.up2", 2'b01, 1'b1, 16'h0100, 1'b1);
    cstep("t6.hold", 2'b01, 1'b0, 16'h0100, 1'b0);

    // Randomised traffic against the integer model
    for (int n = 0; n < 400; n++) begin
      ld  = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 3);
      lv  = (sel == 0) ? 16'h9999 : (sel == 1) ? 16'h0000 : (sel == 2) ? to_bcd($urandom_range(0, 9999))
                                                          : 16'($urandom);
      md  = 2'($urandom_range(0, 3));
      if (md == 2'b00 && $urandom_range(0, 3) != 0) md = 2'b01;
      ci  = ($urandom_range(0, 4) != 0);
      step("rnd", ld, lv, md, ci);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
